// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot registered grant among N requesters, optional hold timeout.
// Latency: request to grant is 1 cycle from idle; release to next grant is 2 cycles (1-cycle gap).
// Backpressure: owner keeps grant while req stays high; others wait until release or timeout.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           expire
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [HW-1:0] hold_cnt;

    logic [PW-1:0] sel;
    logic          sel_vld;
    logic [PW:0]   idx;
    logic [PW-1:0] ptr_nxt;
    logic          others;
    logic          hold_full;

    // Cyclic first-set scan starting at ptr; idx is one bit wider so ptr+i never overflows before the wrap.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N))
                idx = idx - (PW+1)'(N);
            if (!sel_vld && req[idx[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel     = idx[PW-1:0];
            end
        end
    end

    assign ptr_nxt   = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
    assign others    = |(req & ~gnt);
    assign hold_full = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            expire   <= 1'b0;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
        end else begin
            expire <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (sel_vld) begin
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << sel;
                        gnt_id   <= IDW'(sel);
                        gnt_vld  <= 1'b1;
                        owner    <= sel;
                        hold_cnt <= HW'(1);
                        state    <= GRANT;
                    end else begin
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[owner] || (hold_full && others)) begin
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        expire  <= req[owner];
                        ptr     <= ptr_nxt;
                        state   <= GAP;
                    end else if (MAX_HOLD != 0 && !hold_full) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: N=4 with MAX_HOLD=4, plus N=3 with the timeout disabled.
module tb_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       expire;

    logic [2:0] req3;
    logic [2:0] gnt3;
    logic [1:0] gnt_id3;
    logic       gnt_vld3;
    logic       expire3;

    int vectors     = 0;
    int miscompares = 0;

    rr_arbiter #(.N(4), .IDW(2), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .expire(expire)
    );

    rr_arbiter #(.N(3), .IDW(2), .MAX_HOLD(0)) dut3 (
        .clk(clk), .rst(rst), .req(req3),
        .gnt(gnt3), .gnt_id(gnt_id3), .gnt_vld(gnt_vld3), .expire(expire3)
    );

    task automatic expect_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        req3 = '0;
        cyc();
        cyc();
        expect_eq("rst_gnt",    16'(gnt),     16'h0);
        expect_eq("rst_vld",    16'(gnt_vld), 16'h0);
        expect_eq("rst_expire", 16'(expire),  16'h0);
        expect_eq("rst_id",     16'(gnt_id),  16'h0);
        expect_eq("rst_gnt3",   16'(gnt3),    16'h0);

        // single requester
        rst = 1'b0;
        req = 4'b0100;
        cyc();
        expect_eq("single_gnt", 16'(gnt),     16'h4);
        expect_eq("single_id",  16'(gnt_id),  16'h2);
        expect_eq("single_vld", 16'(gnt_vld), 16'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_eq("single_hold", 16'(gnt), 16'h4);
        end
        req = 4'b0000;
        cyc();
        expect_eq("single_drop", 16'(gnt), 16'h0);
        cyc();
        expect_eq("single_idle", 16'(gnt),     16'h0);
        expect_eq("single_ivld", 16'(gnt_vld), 16'h0);

        // reset mid-grant, pointer must return to 0
        req = 4'b0100;
        cyc();
        expect_eq("pre_rst_gnt", 16'(gnt), 16'h4);
        rst = 1'b1;
        cyc();
        expect_eq("midrst_gnt",    16'(gnt),     16'h0);
        expect_eq("midrst_vld",    16'(gnt_vld), 16'h0);
        expect_eq("midrst_expire", 16'(expire),  16'h0);
        rst = 1'b0;
        req = 4'b1111;
        cyc();

        // rotation: each owner holds 3 cycles then drops for one
        for (int k = 0; k < 4; k++) begin
            expect_eq("rot_gnt", 16'(gnt),    16'(1 << k));
            expect_eq("rot_id",  16'(gnt_id), 16'(k));
            cyc();
            expect_eq("rot_hold", 16'(gnt), 16'(1 << k));
            cyc();
            expect_eq("rot_hold", 16'(gnt), 16'(1 << k));
            req = 4'b1111 & ~4'(1 << k);
            cyc();
            expect_eq("rot_gap",    16'(gnt),     16'h0);
            expect_eq("rot_gapvld", 16'(gnt_vld), 16'h0);
            req = 4'b1111;
            cyc();
        end
        expect_eq("rot_wrap", 16'(gnt), 16'h1);

        // timeout under contention
        rst = 1'b1;
        req = '0;
        cyc();
        rst = 1'b0;
        req = 4'b0011;
        cyc();
        for (int i = 0; i < 4; i++) begin
            expect_eq("to_hold",   16'(gnt),    16'h1);
            expect_eq("to_noexp",  16'(expire), 16'h0);
            cyc();
        end
        expect_eq("to_drop",   16'(gnt),    16'h0);
        expect_eq("to_expire", 16'(expire), 16'h1);
        cyc();
        expect_eq("to_next",   16'(gnt),    16'h2);
        expect_eq("to_expclr", 16'(expire), 16'h0);

        // saturated hold with no contention, then late preemption
        rst = 1'b1;
        req = '0;
        cyc();
        rst = 1'b0;
        req = 4'b0001;
        cyc();
        for (int i = 0; i < 20; i++) begin
            expect_eq("sat_gnt",    16'(gnt),    16'h1);
            expect_eq("sat_noexp",  16'(expire), 16'h0);
            cyc();
        end
        req = 4'b1001;
        cyc();
        expect_eq("late_expire", 16'(expire), 16'h1);
        expect_eq("late_gap",    16'(gnt),    16'h0);
        cyc();
        expect_eq("late_gnt",    16'(gnt),    16'h8);
        expect_eq("late_id",     16'(gnt_id), 16'h3);
        expect_eq("late_expclr", 16'(expire), 16'h0);

        // N=3 wrap and disabled timeout
        rst  = 1'b1;
        req  = '0;
        req3 = '0;
        cyc();
        rst  = 1'b0;
        req3 = 3'b100;
        cyc();
        expect_eq("n3_gnt2", 16'(gnt3),    16'h4);
        expect_eq("n3_id2",  16'(gnt_id3), 16'h2);
        req3 = 3'b111;
        cyc();
        expect_eq("n3_ignore", 16'(gnt3), 16'h4);
        req3 = 3'b011;
        cyc();
        expect_eq("n3_gap", 16'(gnt3), 16'h0);
        req3 = 3'b111;
        cyc();
        expect_eq("n3_wrap", 16'(gnt3),    16'h1);
        expect_eq("n3_id0",  16'(gnt_id3), 16'h0);
        for (int i = 0; i < 100; i++) begin
            cyc();
            expect_eq("n3_nohold_gnt", 16'(gnt3),    16'h1);
            expect_eq("n3_nohold_exp", 16'(expire3), 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
